// File: rtl/sr_cmd_gen.sv
// Set/clear command generator: synchronizes and debounces two operator buttons and
// issues spaced, mutually exclusive single-cycle s/r strobes to a downstream SR flip-flop.
module sr_cmd_gen #(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_btn,
  input  logic             clr_btn,
  input  logic             en,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             conflict,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_e;
  typedef enum logic [1:0] {PEND_NONE, PEND_SET, PEND_CLR} pend_e;

  // Bit 0 carries the set path, bit 1 the clear path.
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            db_q, db_d, db_dly_q, db_dly_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            req_c;
  logic                  set_acc_c, clr_acc_c, conf_c, launch_c;
  pend_e                 pend_q, pend_d, pend_in_c;
  state_e                state_q, state_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;
  logic [CNT_W-1:0]      cmd_count_q, cmd_count_d;

  // Input synchronizers, debounce counters and edge detect.
  always_comb begin
    sync1_d  = {clr_btn, set_btn};
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign req_c = db_q & ~db_dly_q;

  // Accepted requests merged into the pending slot; a fresh request wins over an older one.
  always_comb begin
    set_acc_c = en & req_c[0] & ~req_c[1];
    clr_acc_c = en & req_c[1] & ~req_c[0];
    conf_c    = en & req_c[0] & req_c[1];
    pend_in_c = pend_q;
    if (conf_c)         pend_in_c = PEND_NONE;
    else if (set_acc_c) pend_in_c = PEND_SET;
    else if (clr_acc_c) pend_in_c = PEND_CLR;
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pend_d    = pend_in_c;
    launch_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_in_c != PEND_NONE) begin
          state_d  = ST_PULSE;
          pend_d   = PEND_NONE;
          launch_c = 1'b1;
        end
      end
      ST_PULSE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          if (pend_in_c != PEND_NONE) begin
            state_d  = ST_PULSE;
            pend_d   = PEND_NONE;
            launch_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, registered below.
  always_comb begin
    s_d         = launch_c && (pend_in_c == PEND_SET);
    r_d         = launch_c && (pend_in_c == PEND_CLR);
    busy_d      = (state_d != ST_IDLE);
    conflict_d  = conf_c;
    cmd_count_d = cmd_count_q + CNT_W'(launch_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_dly_q    <= '0;
      db_cnt_q    <= '0;
      pend_q      <= PEND_NONE;
      gap_cnt_q   <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      busy_q      <= 1'b0;
      conflict_q  <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_dly_q    <= db_dly_d;
      db_cnt_q    <= db_cnt_d;
      pend_q      <= pend_d;
      gap_cnt_q   <= gap_cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      conflict_q  <= conflict_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign conflict  = conflict_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: default instance plus a 2-bit counter variant
// and a long-gap variant sharing the same stimulus.
module tb_sr_cmd_gen;

  logic       clk = 1'b0;
  logic       rst_n, set_btn, clr_btn, en;
  logic       s, r, busy, conflict;
  logic [7:0] cmd_count;
  logic       s2, r2, busy2, conflict2;
  logic [1:0] cmd_count2;
  logic       s_g, r_g, busy_g, conflict_g;
  logic [7:0] cmd_count_g;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  sr_cmd_gen dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn), .en(en),
    .s(s), .r(r), .busy(busy), .conflict(conflict), .cmd_count(cmd_count)
  );

  sr_cmd_gen #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn), .en(en),
    .s(s2), .r(r2), .busy(busy2), .conflict(conflict2), .cmd_count(cmd_count2)
  );

  sr_cmd_gen #(.GAP_CYCLES(10)) dut_g (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn), .en(en),
    .s(s_g), .r(r_g), .busy(busy_g), .conflict(conflict_g), .cmd_count(cmd_count_g)
  );

  task automatic test_reset();
    rst_n = 1'b0; set_btn = 1'b0; clr_btn = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_btn = ~set_btn;
      if (k % 2 == 0) clr_btn = ~clr_btn;
      @(negedge clk);
      checks++;
      if ({s, r, busy, conflict} !== 4'b0000 || cmd_count !== 8'd0) begin
        errors++;
        $display("FAIL reset k=%0d got s=%b r=%b busy=%b conflict=%b cnt=%0d exp all 0",
                 k, s, r, busy, conflict, cmd_count);
      end
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_set();
    logic es, eb;
    set_btn = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      es = (k == 6);
      eb = (k >= 6 && k <= 9);
      checks++;
      if (s !== es || r !== 1'b0 || busy !== eb) begin
        errors++;
        $display("FAIL clean_set edge=%0d got s=%b r=%b busy=%b exp s=%b r=0 busy=%b",
                 k, s, r, busy, es, eb);
      end
    end
    exp_cnt = 1;
    checks++;
    if (cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL clean_set_count got %0d exp %0d", cmd_count, exp_cnt);
    end
    set_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_bounce();
    int nstrobe;
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 0; k < 4; k++) begin
        set_btn = (k < 3);
        @(negedge clk);
        checks++;
        if (s !== 1'b0 || r !== 1'b0) begin
          errors++;
          $display("FAIL bounce rep=%0d k=%0d got s=%b r=%b exp 0 0", rep, k, s, r);
        end
      end
    end
    set_btn = 1'b0;
    nstrobe = 0;
    repeat (10) begin
      @(negedge clk);
      if (s) nstrobe++;
    end
    checks++;
    if (nstrobe != 0) begin
      errors++;
      $display("FAIL bounce_quiet got %0d strobes exp 0", nstrobe);
    end
    set_btn = 1'b1;
    nstrobe = 0;
    repeat (12) begin
      @(negedge clk);
      if (s) nstrobe++;
    end
    exp_cnt++;
    checks++;
    if (nstrobe != 1 || cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL bounce_held got %0d strobes cnt=%0d exp 1 strobe cnt=%0d",
               nstrobe, cmd_count, exp_cnt);
    end
    set_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Clear accepted one cycle after the set strobe; enable drops mid-gap.
  task automatic test_back_to_back();
    logic es, er;
    for (int k = 0; k <= 14; k++) begin
      set_btn = 1'b1;
      clr_btn = (k >= 2);
      if (k >= 9) en = 1'b0;
      @(negedge clk);
      es = (k == 6);
      er = (k == 10);
      checks++;
      if (s !== es || r !== er) begin
        errors++;
        $display("FAIL back_to_back edge=%0d got s=%b r=%b exp s=%b r=%b", k, s, r, es, er);
      end
    end
    exp_cnt += 2;
    checks++;
    if (cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL back_to_back_count got %0d exp %0d", cmd_count, exp_cnt);
    end
    en = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  // Set re-accepted inside the long gap overrides a pending clear.
  task automatic test_replace();
    logic es, er, esg;
    for (int k = 0; k <= 20; k++) begin
      set_btn = (k <= 3) || (k >= 8);
      clr_btn = (k >= 2);
      @(negedge clk);
      esg = (k == 6) || (k == 17);
      es  = (k == 6) || (k == 14);
      er  = (k == 10);
      checks++;
      if (s_g !== esg || r_g !== 1'b0) begin
        errors++;
        $display("FAIL replace_gap edge=%0d got s=%b r=%b exp s=%b r=0", k, s_g, r_g, esg);
      end
      checks++;
      if (s !== es || r !== er) begin
        errors++;
        $display("FAIL replace_main edge=%0d got s=%b r=%b exp s=%b r=%b", k, s, r, es, er);
      end
    end
    exp_cnt += 3;
    set_btn = 1'b0; clr_btn = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_conflict();
    logic ec;
    set_btn = 1'b1; clr_btn = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      ec = (k == 6);
      checks++;
      if (conflict !== ec || s !== 1'b0 || r !== 1'b0) begin
        errors++;
        $display("FAIL conflict edge=%0d got conflict=%b s=%b r=%b exp conflict=%b s=0 r=0",
                 k, conflict, s, r, ec);
      end
    end
    checks++;
    if (cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL conflict_count got %0d exp %0d", cmd_count, exp_cnt);
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_enable();
    set_btn = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      en = (k >= 9);
      @(negedge clk);
      checks++;
      if (s !== 1'b0 || r !== 1'b0) begin
        errors++;
        $display("FAIL enable edge=%0d got s=%b r=%b exp 0 0", k, s, r);
      end
    end
    checks++;
    if (cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL enable_count got %0d exp %0d", cmd_count, exp_cnt);
    end
    set_btn = 1'b0; en = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Reset mid-strobe, then a level held through reset release.
  task automatic test_async_reset();
    logic es;
    set_btn = 1'b1;
    for (int k = 0; k <= 6; k++) @(negedge clk);
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got s=%b exp 1", s);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (s !== 1'b0 || busy !== 1'b0 || cmd_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got s=%b busy=%b cnt=%0d exp 0 0 0", s, busy, cmd_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      es = (k == 6);
      checks++;
      if (s !== es) begin
        errors++;
        $display("FAIL held_through_reset edge=%0d got s=%b exp %b", k, s, es);
      end
    end
    exp_cnt = 1;
    checks++;
    if (cmd_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL held_count got %0d exp %0d", cmd_count, exp_cnt);
    end
    set_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      set_btn = 1'b1;
      repeat (8) @(negedge clk);
      set_btn = 1'b0;
      repeat (8) @(negedge clk);
      if (p == 4) begin
        checks++;
        if (cmd_count2 !== 2'd0) begin
          errors++;
          $display("FAIL wrap_at_4 got %0d exp 0", cmd_count2);
        end
      end
    end
    checks++;
    if (cmd_count2 !== 2'd1 || cmd_count !== 8'd5) begin
      errors++;
      $display("FAIL wrap_final got cnt2=%0d cnt8=%0d exp cnt2=1 cnt8=5", cmd_count2, cmd_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; set_btn = 1'b0; clr_btn = 1'b0; en = 1'b1;
    test_reset();
    test_clean_set();
    test_bounce();
    test_back_to_back();
    test_replace();
    test_conflict();
    test_enable();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
